// File: rtl/channel_llr_loader.sv
// Loads P channel LLRs per beat into bit-reversed storage and presents the frame as a flat bus; CHANNEL_PINGPONG_EN adds a second bank.
// Frame visible one cycle after its last beat; in_ready drops while no bank is free to write.
module channel_llr_loader #(
    parameter int n = 3,
    parameter int Q = 6,
    parameter int P = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [P*Q-1:0]        in_data,
    output logic                  frame_valid,
    input  logic                  dec_start,
    input  logic                  dec_done,
    output logic                  dec_active,
    output logic [(1<<n)*Q-1:0]   channel_data
);
    localparam int N  = 1 << n;
    localparam int LP = $clog2(P);
    localparam int CW = (n - LP) > 0 ? (n - LP) : 1;
    localparam int NB = N / P;
`ifdef CHANNEL_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, IN_USE} bank_state_t;

    bank_state_t   state     [NBANK];
    bank_state_t   state_nxt [NBANK];
    logic          wr_bank, rd_bank, wr_bank_nxt, rd_bank_nxt;
    logic [CW-1:0] beat_cnt;
    logic [Q-1:0]  mem [NBANK][N];
    logic [n-1:0]  wr_addr [P];
    logic          beat_acc, last_beat, start_acc, done_acc;

    function automatic logic [n-1:0] bitrev(input logic [n-1:0] x);
        logic [n-1:0] r;
        r = '0;
        for (int m = 0; m < n; m++) r[n-1-m] = x[m];
        return r;
    endfunction

    assign in_ready    = !rst && (state[wr_bank] == EMPTY || state[wr_bank] == FILLING);
    assign frame_valid = (state[rd_bank] == FULL);
    assign dec_active  = (state[rd_bank] == IN_USE);
    assign beat_acc    = in_valid && in_ready;
    assign last_beat   = beat_acc && (beat_cnt == CW'(NB - 1));
    assign start_acc   = dec_start && frame_valid;
    assign done_acc    = dec_done && dec_active;

    // A bank being written is never IN_USE, so write and decoder events never hit the same bank.
    always_comb begin
        for (int b = 0; b < NBANK; b++) state_nxt[b] = state[b];
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;
        if (beat_acc) state_nxt[wr_bank] = last_beat ? FULL : FILLING;
        if (start_acc) state_nxt[rd_bank] = IN_USE;
        if (done_acc) state_nxt[rd_bank] = EMPTY;
`ifdef CHANNEL_PINGPONG_EN
        if (last_beat) wr_bank_nxt = ~wr_bank;
        if (done_acc) rd_bank_nxt = ~rd_bank;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) state[b] <= EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            for (int b = 0; b < NBANK; b++) state[b] <= state_nxt[b];
            wr_bank <= wr_bank_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    always_comb begin
        for (int k = 0; k < P; k++) begin
            wr_addr[k] = bitrev(n'(int'(beat_cnt) * P + k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            for (int b = 0; b < NBANK; b++)
                for (int j = 0; j < N; j++) mem[b][j] <= '0;
        end else if (beat_acc) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
            for (int k = 0; k < P; k++) mem[wr_bank][wr_addr[k]] <= in_data[k*Q +: Q];
        end
    end

    always_comb begin
        channel_data = '0;
        for (int j = 0; j < N; j++) channel_data[j*Q +: Q] = mem[rd_bank][j];
    end
endmodule

// File: tb/tb_channel_llr_loader.sv
// Randomized and directed bench for channel_llr_loader against a frame/bank occupancy model.
module tb_channel_llr_loader;
    localparam int n  = 3;
    localparam int Q  = 6;
    localparam int P  = 2;
    localparam int N  = 8;
    localparam int NB = N / P;
    localparam int W  = N * Q;
`ifdef CHANNEL_PINGPONG_EN
    localparam int NBK = 2;
`else
    localparam int NBK = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, frame_valid, dec_start, dec_done, dec_active;
    logic [P*Q-1:0] in_data;
    logic [W-1:0]   channel_data;
    logic in_valid8, in_ready8, frame_valid8, dec_start8, dec_done8, dec_active8;
    logic [W-1:0]   in_data8, channel_data8;

    channel_llr_loader #(.n(n), .Q(Q), .P(P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .frame_valid(frame_valid), .dec_start(dec_start), .dec_done(dec_done),
        .dec_active(dec_active), .channel_data(channel_data)
    );

    channel_llr_loader #(.n(n), .Q(Q), .P(N)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .frame_valid(frame_valid8), .dec_start(dec_start8), .dec_done(dec_done8),
        .dec_active(dec_active8), .channel_data(channel_data8)
    );

    int checks = 0;
    int errors = 0;

    // Model: per-bank LLR images, count of occupied banks, oldest-bank pointer, claim flag.
    logic [Q-1:0] mmem [2][N];
    int occ, rd, cnt;
    bit claimed;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bitrev(input int i);
        int r = 0;
        for (int b = 0; b < n; b++) if (((i >> b) & 1) != 0) r |= 1 << (n - 1 - b);
        return r;
    endfunction

    function automatic logic [W-1:0] img(input logic [Q-1:0] f [N]);
        logic [W-1:0] d = '0;
        for (int i = 0; i < N; i++) d[bitrev(i)*Q +: Q] = f[i];
        return d;
    endfunction

    function automatic logic [W-1:0] model_data();
        logic [W-1:0] d = '0;
        for (int j = 0; j < N; j++) d[j*Q +: Q] = mmem[rd][j];
        return d;
    endfunction

    task automatic model_edge(output bit acc);
        bit rdy, fv, act;
        int wb;
        rdy = !rst && occ < NBK;
        fv  = !claimed && occ > 0;
        act = claimed;
        acc = 1'b0;
        if (rst) begin
            for (int b = 0; b < 2; b++) for (int j = 0; j < N; j++) mmem[b][j] = '0;
            occ = 0; rd = 0; cnt = 0; claimed = 0;
        end else begin
            wb = (rd + occ) % NBK;
            if (in_valid && rdy) begin
                acc = 1'b1;
                for (int k = 0; k < P; k++) mmem[wb][bitrev(cnt*P + k)] = in_data[k*Q +: Q];
                cnt++;
                if (cnt == NB) begin cnt = 0; occ++; end
            end
            if (dec_start && fv) claimed = 1;
            if (dec_done && act) begin claimed = 0; occ--; rd = (rd + 1) % NBK; end
        end
    endtask

    task automatic cycle(output bit acc);
        @(posedge clk);
        model_edge(acc);
        #1;
        check("in_ready", W'(in_ready), W'(!rst && occ < NBK));
        check("frame_valid", W'(frame_valid), W'(!claimed && occ > 0));
        check("dec_active", W'(dec_active), W'(claimed));
        check("channel_data", channel_data, model_data());
        in_valid = 0; dec_start = 0; dec_done = 0; in_valid8 = 0;
    endtask

    task automatic send_frame(input logic [Q-1:0] f [N], input bit gaps);
        bit acc;
        for (int b = 0; b < NB; b++) begin
            int tries = 0;
            acc = 0;
            while (!acc) begin
                for (int k = 0; k < P; k++) in_data[k*Q +: Q] = f[b*P + k];
                in_valid = gaps ? (tries % 2 == 1) : 1'b1;
                cycle(acc);
                tries++;
                if (!acc && tries > 40) begin
                    check("beat_timeout", W'(0), W'(1));
                    return;
                end
            end
        end
    endtask

    task automatic offer_frame(input logic [Q-1:0] f [N], input int ncyc, input int done_at,
                               input logic [W-1:0] hold, output int sent);
        bit acc;
        sent = 0;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = 1'b1;
            for (int k = 0; k < P; k++) in_data[k*Q +: Q] = f[(sent % NB)*P + k];
            if (done_at >= 0 && sent >= NB) in_valid = 1'b0;
            dec_done = (c == done_at);
            cycle(acc);
            if (acc) sent++;
            if (c == done_at - 1) check("hold_prev", channel_data, hold);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int t = 0; t < 10 && occ > 0; t++) begin
            if (claimed) dec_done = 1; else dec_start = 1;
            cycle(acc);
        end
        check("drained", W'(frame_valid || dec_active), W'(0));
    endtask

    initial begin
        bit acc;
        int sent;
        logic [Q-1:0] fa [N], fb [N], fc [N], fe [N];
        logic [W-1:0] e_all20;
        rst = 1; in_valid = 0; in_data = '0; dec_start = 0; dec_done = 0;
        in_valid8 = 0; in_data8 = '0; dec_start8 = 0; dec_done8 = 0;
        occ = 0; rd = 0; cnt = 0; claimed = 0;
        repeat (3) cycle(acc);
        check("rst_data", channel_data, W'(0));
        check("rst_ready", W'(in_ready), W'(0));
        check("rst8_fv", W'(frame_valid8), W'(0));
        rst = 0; #1;
        check("ready_after_rst", W'(in_ready), W'(1));

        // Natural order frame 1..8.
        for (int i = 0; i < N; i++) fa[i] = Q'(i + 1);
        fe = '{6'd1, 6'd5, 6'd3, 6'd7, 6'd2, 6'd6, 6'd4, 6'd8};
        send_frame(fa, 0);
        check("t1_fv", W'(frame_valid), W'(1));
        for (int j = 0; j < N; j++) check("t1_addr", W'(channel_data[j*Q +: Q]), W'(fe[j]));
        drain();

        // Negative LLRs with valid gaps.
        for (int i = 0; i < N; i++) fb[i] = 6'h20;
        e_all20 = {N{6'h20}};
        send_frame(fb, 1);
        check("t2_neg", channel_data, e_all20);
        drain();

        // Next frame streamed while the previous one is claimed.
        for (int i = 0; i < N; i++) begin fa[i] = Q'($urandom); fb[i] = Q'($urandom); end
        send_frame(fa, 0);
        dec_start = 1; cycle(acc);
        check("t3_active", W'(dec_active), W'(1));
        offer_frame(fb, 14, 6, img(fa), sent);
        check("t3_sent", W'(sent), W'(NB));
        check("t3_B", channel_data, img(fb));
        check("t3_fv", W'(frame_valid), W'(1));
        drain();

        // Back-pressure with no decoder activity.
        send_frame(fa, 0);
        offer_frame(fb, 12, -1, '0, sent);
        check("bp_sent", W'(sent), W'(NBK == 2 ? NB : 0));
        check("bp_ready", W'(in_ready), W'(0));
        check("bp_showA", channel_data, img(fa));
        drain();

        // Spurious decoder controls.
        dec_start = 1; cycle(acc);
        check("sp_start", W'({frame_valid, dec_active}), W'(0));
        dec_done = 1; cycle(acc);
        check("sp_done", W'({frame_valid, dec_active}), W'(0));
        send_frame(fb, 0);
        dec_start = 1; cycle(acc);
        dec_start = 1; dec_done = 1; cycle(acc);
        check("sp_both_act", W'(dec_active), W'(0));
        check("sp_both_fv", W'(frame_valid), W'(0));

        // Reset mid-frame.
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < P; k++) in_data[k*Q +: Q] = Q'($urandom);
            in_valid = 1; cycle(acc);
        end
        rst = 1; cycle(acc);
        rst = 0;
        for (int i = 0; i < N; i++) fa[i] = Q'(i + 1);
        send_frame(fa, 0);
        for (int j = 0; j < N; j++) check("rst_mid_addr", W'(channel_data[j*Q +: Q]), W'(fe[j]));
        drain();

        // P = N: one beat is a whole frame.
        for (int i = 0; i < N; i++) begin fc[i] = Q'($urandom); in_data8[i*Q +: Q] = fc[i]; end
        check("p8_fv_before", W'(frame_valid8), W'(0));
        in_valid8 = 1; cycle(acc);
        check("p8_fv", W'(frame_valid8), W'(1));
        check("p8_data", channel_data8, img(fc));
        check("p8_ready", W'(in_ready8), W'(NBK == 2 ? 1 : 0));

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = (P*Q)'($urandom);
            dec_start = ($urandom_range(0, 3) == 0);
            dec_done  = ($urandom_range(0, 3) == 0);
            cycle(acc);
        end
        rst = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
